// File: rtl/axi_stream_video_mux_n.sv
// Purpose: N-input AXI4-Stream video source selector that only changes source on frame (SOF) boundaries.
// Latency: one cycle from an accepted input beat to m_* (single output register slice).
// Backpressure: the active input sees ready only when the output slice is free; unselected inputs see DRAIN_UNSEL.
//
// Ports:
//   axi_clk_i, axi_rstn_i        : stream clock, synchronous active-low reset
//   sel_i                        : requested source; codes >= NUM_IN turn the output off
//   s_tdata/tvalid/tuser/tlast_i : NUM_IN packed input streams (stream k at [k*DW +: DW])
//   s_tready_o                   : per-input ready
//   m_tdata/tvalid/tuser/tlast_o : registered output stream, m_tready_i is its ready
//   active_sel_o                 : source currently locked
//   switch_pending_o             : a requested source change has not taken effect yet
//   frames_o, dropped_o          : optional statistics, present only when VIDEO_MUX_STATS_EN is defined
module axi_stream_video_mux_n #(
  parameter int NUM_IN      = 4,
  parameter int DW          = 32,
  parameter int SEL_W       = $clog2(NUM_IN) + 1,
  parameter int DRAIN_UNSEL = 1
) (
  input  logic                 axi_clk_i,
  input  logic                 axi_rstn_i,
  input  logic [SEL_W-1:0]     sel_i,
  input  logic [NUM_IN*DW-1:0] s_tdata_i,
  input  logic [NUM_IN-1:0]    s_tvalid_i,
  input  logic [NUM_IN-1:0]    s_tuser_i,
  input  logic [NUM_IN-1:0]    s_tlast_i,
  output logic [NUM_IN-1:0]    s_tready_o,
  output logic [DW-1:0]        m_tdata_o,
  output logic                 m_tvalid_o,
  output logic                 m_tuser_o,
  output logic                 m_tlast_o,
  input  logic                 m_tready_i,
  output logic [SEL_W-1:0]     active_sel_o,
  output logic                 switch_pending_o
`ifdef VIDEO_MUX_STATS_EN
  ,
  output logic [15:0]          frames_o,
  output logic [15:0]          dropped_o
`endif
);

  typedef enum logic [1:0] {
    SYNC = 2'd0,
    PASS = 2'd1,
    OFF  = 2'd2
  } state_t;

  state_t state;

  logic          drain_level;
  logic          reg_free;
  logic          sel_off;
  logic          retarget;
  logic          switch_now;
  logic          take_sel;
  logic [SEL_W-1:0] active_next;

  logic          act_tvalid;
  logic          act_tuser;
  logic          act_tlast;
  logic [DW-1:0] act_tdata;
  logic          act_tready;
  logic          accept;
  logic          load;

  assign drain_level = (DRAIN_UNSEL != 0);
  assign reg_free    = !m_tvalid_o || m_tready_i;
  assign sel_off     = (sel_i >= SEL_W'(NUM_IN));
  assign retarget    = (sel_i != active_sel_o);

  // Select the locked input. Out-of-range codes (OFF) leave everything at 0.
  always_comb begin
    act_tvalid = 1'b0;
    act_tuser  = 1'b0;
    act_tlast  = 1'b0;
    act_tdata  = '0;
    for (int k = 0; k < NUM_IN; k++) begin
      if (active_sel_o == SEL_W'(k)) begin
        act_tvalid = s_tvalid_i[k];
        act_tuser  = s_tuser_i[k];
        act_tlast  = s_tlast_i[k];
        act_tdata  = s_tdata_i[k*DW +: DW];
      end
    end
  end

  // Only act on a registered pending flag while sel_i still disagrees, so a
  // request that bounces back to the current source never causes a switch.
  assign switch_now = (state == PASS) && switch_pending_o && retarget &&
                      act_tvalid && act_tuser;

  always_comb begin
    act_tready = 1'b0;
    case (state)
      // Pre-SOF beats are discarded freely; the SOF waits for the output slice.
      // A retarget in the same cycle takes priority, so the SOF is not taken.
      SYNC:    act_tready = act_tuser ? (reg_free && !retarget) : 1'b1;
      // A switching SOF belongs to the old source and is left on its input.
      PASS:    act_tready = (act_tuser && switch_pending_o && retarget) ? 1'b0 : reg_free;
      default: act_tready = 1'b0;
    endcase
  end

  always_comb begin
    s_tready_o = {NUM_IN{drain_level}};
    for (int k = 0; k < NUM_IN; k++) begin
      if (state != OFF && active_sel_o == SEL_W'(k)) begin
        s_tready_o[k] = act_tready;
      end
    end
  end

  assign accept = (state != OFF) && act_tvalid && act_tready;
  // In SYNC only the SOF is forwarded; everything accepted before it is dropped.
  assign load   = accept && ((state == PASS) || act_tuser);

  assign take_sel    = ((state == SYNC) && retarget) || switch_now || (state == OFF);
  assign active_next = take_sel ? sel_i : active_sel_o;

  always_ff @(posedge axi_clk_i) begin
    if (!axi_rstn_i) begin
      state            <= SYNC;
      active_sel_o     <= '0;
      switch_pending_o <= 1'b0;
      m_tvalid_o       <= 1'b0;
      m_tdata_o        <= '0;
      m_tuser_o        <= 1'b0;
      m_tlast_o        <= 1'b0;
    end else begin
      active_sel_o     <= active_next;
      // Compared against the next locked source so the flag drops on the same
      // edge that completes a switch.
      switch_pending_o <= (sel_i != active_next);

      case (state)
        SYNC: begin
          if (retarget) begin
            state <= sel_off ? OFF : SYNC;
          end else if (load) begin
            state <= PASS;
          end
        end
        PASS: begin
          if (switch_now) begin
            state <= sel_off ? OFF : SYNC;
          end
        end
        OFF: begin
          if (!sel_off) begin
            state <= SYNC;
          end
        end
        default: state <= SYNC;
      endcase

      if (load) begin
        m_tvalid_o <= 1'b1;
        m_tdata_o  <= act_tdata;
        m_tuser_o  <= act_tuser;
        m_tlast_o  <= act_tlast;
      end else if (m_tready_i) begin
        m_tvalid_o <= 1'b0;
      end
    end
  end

`ifdef VIDEO_MUX_STATS_EN
  logic sel_change;
  assign sel_change = (active_next != active_sel_o);

  always_ff @(posedge axi_clk_i) begin
    if (!axi_rstn_i) begin
      frames_o  <= '0;
      dropped_o <= '0;
    end else if (sel_change) begin
      frames_o  <= '0;
      dropped_o <= '0;
    end else begin
      if (m_tvalid_o && m_tready_i && m_tuser_o && frames_o != 16'hFFFF) begin
        frames_o <= frames_o + 16'd1;
      end
      if (accept && (state == SYNC) && !act_tuser && dropped_o != 16'hFFFF) begin
        dropped_o <= dropped_o + 16'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_axi_stream_video_mux_n.sv
module tb_axi_stream_video_mux_n;
  localparam int N  = 4;
  localparam int DW = 32;
  localparam int SW = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rstn;
  logic [SW-1:0] sel;
  logic [N*DW-1:0] tdata;
  logic [N-1:0]  tvalid, tuser, tlast, tready, tready0;
  logic [DW-1:0] mdata, mdata0;
  logic          mvalid, muser, mlast, mvalid0, muser0, mlast0, mready;
  logic [SW-1:0] asel, asel0;
  logic          pend, pend0;
`ifdef VIDEO_MUX_STATS_EN
  logic [15:0]   frames, dropped, frames0, dropped0;
`endif

  axi_stream_video_mux_n #(.NUM_IN(N), .DW(DW), .DRAIN_UNSEL(1)) dut (
    .axi_clk_i(clk), .axi_rstn_i(rstn), .sel_i(sel),
    .s_tdata_i(tdata), .s_tvalid_i(tvalid), .s_tuser_i(tuser), .s_tlast_i(tlast),
    .s_tready_o(tready),
    .m_tdata_o(mdata), .m_tvalid_o(mvalid), .m_tuser_o(muser), .m_tlast_o(mlast),
    .m_tready_i(mready), .active_sel_o(asel), .switch_pending_o(pend)
`ifdef VIDEO_MUX_STATS_EN
    , .frames_o(frames), .dropped_o(dropped)
`endif
  );

  axi_stream_video_mux_n #(.NUM_IN(N), .DW(DW), .DRAIN_UNSEL(0)) dut0 (
    .axi_clk_i(clk), .axi_rstn_i(rstn), .sel_i(sel),
    .s_tdata_i(tdata), .s_tvalid_i(tvalid), .s_tuser_i(tuser), .s_tlast_i(tlast),
    .s_tready_o(tready0),
    .m_tdata_o(mdata0), .m_tvalid_o(mvalid0), .m_tuser_o(muser0), .m_tlast_o(mlast0),
    .m_tready_i(mready), .active_sel_o(asel0), .switch_pending_o(pend0)
`ifdef VIDEO_MUX_STATS_EN
    , .frames_o(frames0), .dropped_o(dropped0)
`endif
  );

  // Beat encoding used everywhere in the bench: {tuser, tlast, tdata}.
  logic [33:0] src_q [N][$];
  logic [33:0] out_q [$];
  logic [33:0] exp_q [$];
  bit          pres [N];
  int          acc_cnt [N];
  bit          rdy_rand;
  logic [SW-1:0] sel_cmd;
  logic        rstn_cmd;
  logic [33:0] cur_m, prv_m;
  logic        cur_vld, prv_vld, cur_rdy, prv_rdy;
  int          n_cmp, n_err;

  // One clock: drive on the falling edge, sample 1 ns before the rising edge.
  task automatic step();
    @(negedge clk);
    rstn   = rstn_cmd;
    sel    = sel_cmd;
    mready = rdy_rand ? 1'($urandom_range(0, 1)) : 1'b1;
    for (int k = 0; k < N; k++) begin
      if (!pres[k] && src_q[k].size() > 0 && $urandom_range(0, 3) != 0) pres[k] = 1'b1;
      tvalid[k] = pres[k];
      if (pres[k]) begin
        tuser[k] = src_q[k][0][33];
        tlast[k] = src_q[k][0][32];
        tdata[k*DW +: DW] = src_q[k][0][31:0];
      end else begin
        tuser[k] = 1'b0;
        tlast[k] = 1'b0;
        tdata[k*DW +: DW] = $urandom;
      end
    end
    #4;
    for (int k = 0; k < N; k++) begin
      if (pres[k] && tready[k]) begin
        void'(src_q[k].pop_front());
        pres[k] = 1'b0;
        acc_cnt[k]++;
      end
    end
    prv_m = cur_m; prv_vld = cur_vld; prv_rdy = cur_rdy;
    cur_m = {muser, mlast, mdata}; cur_vld = mvalid; cur_rdy = mready;
    if (mvalid && mready) out_q.push_back(cur_m);
  endtask

  // A w x h frame: SOF on the first beat, EOL on the last beat of each line.
  task automatic push_frame(input int k, input int w, input int h, input bit expect_it);
    logic [33:0] b;
    for (int y = 0; y < h; y++) begin
      for (int x = 0; x < w; x++) begin
        b = {1'(x == 0 && y == 0), 1'(x == w - 1), 32'($urandom)};
        src_q[k].push_back(b);
        if (expect_it) exp_q.push_back(b);
      end
    end
  endtask

  task automatic push_junk(input int k, input int n);
    for (int i = 0; i < n; i++) src_q[k].push_back({1'b0, 1'($urandom_range(0, 1)), 32'($urandom)});
  endtask

  task automatic wait_out(input int n, input int budget);
    for (int i = 0; i < budget && out_q.size() < n; i++) step();
    repeat (4) step();
  endtask

  task automatic clear_traffic();
    out_q.delete();
    exp_q.delete();
  endtask

  task automatic test_reset();
    rstn_cmd = 1'b0;
    repeat (3) step();
    n_cmp++; if (mvalid !== 1'b0) begin n_err++; $display("FAIL rst_tvalid: got %b want 0", mvalid); end
    n_cmp++; if (mdata !== '0) begin n_err++; $display("FAIL rst_tdata: got %h want 0", mdata); end
    n_cmp++; if (muser !== 1'b0 || mlast !== 1'b0) begin n_err++; $display("FAIL rst_user_last: got %b%b want 00", muser, mlast); end
    n_cmp++; if (asel !== 3'd0) begin n_err++; $display("FAIL rst_active_sel: got %0d want 0", asel); end
    n_cmp++; if (pend !== 1'b0) begin n_err++; $display("FAIL rst_pending: got %b want 0", pend); end
    rstn_cmd = 1'b1;
    step();
  endtask

  task automatic test_sync_drop();
    sel_cmd = 3'd2;
    repeat (2) step();
    n_cmp++; if (asel !== 3'd2) begin n_err++; $display("FAIL sync_retarget: got %0d want 2", asel); end
    clear_traffic();
    acc_cnt[2] = 0;
    push_junk(2, 3);
    push_frame(2, 4, 2, 1'b1);
    wait_out(8, 200);
    n_cmp++; if (acc_cnt[2] !== 11) begin n_err++; $display("FAIL sync_accepted: got %0d want 11", acc_cnt[2]); end
    n_cmp++; if (out_q.size() !== exp_q.size()) begin n_err++; $display("FAIL sync_count: got %0d want %0d", out_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < out_q.size(); i++) begin
      n_cmp++; if (out_q[i] !== exp_q[i]) begin n_err++; $display("FAIL sync_beat[%0d]: got %h want %h", i, out_q[i], exp_q[i]); end
    end
`ifdef VIDEO_MUX_STATS_EN
    n_cmp++; if (frames !== 16'd1) begin n_err++; $display("FAIL stats_frames: got %0d want 1", frames); end
    n_cmp++; if (dropped !== 16'd3) begin n_err++; $display("FAIL stats_dropped: got %0d want 3", dropped); end
`endif
  endtask

  task automatic test_switch();
    bit found;
    clear_traffic();
    acc_cnt[2] = 0;
    push_frame(2, 4, 2, 1'b1);
    for (int i = 0; i < 100 && acc_cnt[2] < 3; i++) step();
    sel_cmd = 3'd1;
    step();
    step();
    n_cmp++; if (pend !== 1'b1) begin n_err++; $display("FAIL switch_pending: got %b want 1", pend); end
    push_frame(2, 4, 2, 1'b0);
    found = 1'b0;
    for (int i = 0; i < 200 && !found; i++) begin
      step();
      if (tvalid[2] && tuser[2] && pend) found = 1'b1;
    end
    n_cmp++; if (!found || tready[2] !== 1'b0) begin n_err++; $display("FAIL switch_hold_sof: found=%b tready=%b want found=1 tready=0", found, tready[2]); end
    step();
    n_cmp++; if (asel !== 3'd1) begin n_err++; $display("FAIL switch_active: got %0d want 1", asel); end
    push_junk(1, 2);
    push_frame(1, 4, 2, 1'b1);
    wait_out(16, 300);
    n_cmp++; if (out_q.size() !== exp_q.size()) begin n_err++; $display("FAIL switch_count: got %0d want %0d", out_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < out_q.size(); i++) begin
      n_cmp++; if (out_q[i] !== exp_q[i]) begin n_err++; $display("FAIL switch_beat[%0d]: got %h want %h", i, out_q[i], exp_q[i]); end
    end
  endtask

  task automatic test_backpressure();
    clear_traffic();
    rdy_rand = 1'b1;
    push_frame(1, 16, 16, 1'b1);
    for (int i = 0; i < 3000 && out_q.size() < 256; i++) begin
      step();
      if (prv_vld && !prv_rdy) begin
        n_cmp++;
        if (cur_vld !== 1'b1 || cur_m !== prv_m) begin
          n_err++; $display("FAIL stall_hold: got vld=%b %h want vld=1 %h", cur_vld, cur_m, prv_m);
        end
      end
    end
    rdy_rand = 1'b0;
    repeat (4) step();
    n_cmp++; if (out_q.size() !== 256) begin n_err++; $display("FAIL bp_count: got %0d want 256", out_q.size()); end
    for (int i = 0; i < exp_q.size() && i < out_q.size(); i++) begin
      n_cmp++; if (out_q[i] !== exp_q[i]) begin n_err++; $display("FAIL bp_beat[%0d]: got %h want %h", i, out_q[i], exp_q[i]); end
    end
  endtask

  task automatic test_off();
    clear_traffic();
    sel_cmd = 3'd7;
    step();
    step();
    n_cmp++; if (pend !== 1'b1) begin n_err++; $display("FAIL off_pending: got %b want 1", pend); end
    push_frame(1, 4, 2, 1'b0);
    for (int i = 0; i < 100 && asel != 3'd7; i++) step();
    n_cmp++; if (asel !== 3'd7) begin n_err++; $display("FAIL off_lock: got %0d want 7", asel); end
    step();
    step();
    n_cmp++; if (mvalid !== 1'b0) begin n_err++; $display("FAIL off_valid_low: got %b want 0", mvalid); end
    repeat (20) step();
    n_cmp++; if (out_q.size() !== 0) begin n_err++; $display("FAIL off_no_output: got %0d beats want 0", out_q.size()); end
    sel_cmd = 3'd0;
    step();
    step();
    n_cmp++; if (asel !== 3'd0) begin n_err++; $display("FAIL on_resync: got %0d want 0", asel); end
    push_junk(0, 2);
    push_frame(0, 4, 2, 1'b1);
    wait_out(8, 200);
    n_cmp++; if (out_q.size() !== exp_q.size()) begin n_err++; $display("FAIL on_count: got %0d want %0d", out_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < out_q.size(); i++) begin
      n_cmp++; if (out_q[i] !== exp_q[i]) begin n_err++; $display("FAIL on_beat[%0d]: got %h want %h", i, out_q[i], exp_q[i]); end
    end
  endtask

  task automatic test_glitch();
    clear_traffic();
    acc_cnt[0] = 0;
    push_frame(0, 4, 4, 1'b1);
    push_frame(0, 4, 2, 1'b1);
    for (int i = 0; i < 100 && acc_cnt[0] < 4; i++) step();
    sel_cmd = 3'd3;
    step();
    step();
    sel_cmd = 3'd0;
    wait_out(24, 300);
    n_cmp++; if (pend !== 1'b0) begin n_err++; $display("FAIL glitch_pending: got %b want 0", pend); end
    n_cmp++; if (asel !== 3'd0) begin n_err++; $display("FAIL glitch_active: got %0d want 0", asel); end
    n_cmp++; if (out_q.size() !== exp_q.size()) begin n_err++; $display("FAIL glitch_count: got %0d want %0d", out_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < out_q.size(); i++) begin
      n_cmp++; if (out_q[i] !== exp_q[i]) begin n_err++; $display("FAIL glitch_beat[%0d]: got %h want %h", i, out_q[i], exp_q[i]); end
    end
  endtask

  task automatic test_drain();
    step();
    for (int k = 0; k < N; k++) begin
      if (asel != 3'(k)) begin
        n_cmp++; if (tready[k] !== 1'b1) begin n_err++; $display("FAIL drain1_ready[%0d]: got %b want 1", k, tready[k]); end
      end
      if (asel0 != 3'(k)) begin
        n_cmp++; if (tready0[k] !== 1'b0) begin n_err++; $display("FAIL drain0_ready[%0d]: got %b want 0", k, tready0[k]); end
      end
    end
  endtask

  task automatic test_reset_mid();
    clear_traffic();
    acc_cnt[0] = 0;
    push_frame(0, 4, 4, 1'b0);
    for (int i = 0; i < 100 && acc_cnt[0] < 5; i++) step();
    rstn_cmd = 1'b0;
    step();
    rstn_cmd = 1'b1;
    step();
    n_cmp++; if (mvalid !== 1'b0) begin n_err++; $display("FAIL rstmid_valid: got %b want 0", mvalid); end
    n_cmp++; if (asel !== 3'd0) begin n_err++; $display("FAIL rstmid_active: got %0d want 0", asel); end
    clear_traffic();
    push_frame(0, 4, 2, 1'b1);
    wait_out(8, 300);
    n_cmp++; if (out_q.size() !== exp_q.size()) begin n_err++; $display("FAIL rstmid_count: got %0d want %0d", out_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < out_q.size(); i++) begin
      n_cmp++; if (out_q[i] !== exp_q[i]) begin n_err++; $display("FAIL rstmid_beat[%0d]: got %h want %h", i, out_q[i], exp_q[i]); end
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    n_cmp = 0; n_err = 0;
    rstn = 1'b0; sel = '0; tdata = '0; tvalid = '0; tuser = '0; tlast = '0; mready = 1'b1;
    rstn_cmd = 1'b0; sel_cmd = '0; rdy_rand = 1'b0;
    cur_m = '0; prv_m = '0; cur_vld = 1'b0; prv_vld = 1'b0; cur_rdy = 1'b1; prv_rdy = 1'b1;
    for (int k = 0; k < N; k++) begin pres[k] = 1'b0; acc_cnt[k] = 0; end
    test_reset();
    test_sync_drop();
    test_switch();
    test_backpressure();
    test_off();
    test_glitch();
    test_drain();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
